// File: rtl/axi4_lite_reg_bank_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes,
// channel FSM states and the byte-offset helper.
package axi4_lite_reg_bank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_ACCEPT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_ACCEPT,
        R_RESP
    } rd_state_t;

    // Number of address bits that select a byte inside one data word.
    function automatic int ofs_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/aix4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Params: ADDR_BIT_WIDTH (byte address), DATA_BIT_WIDTH (32 or 64).
interface aix4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slv_port (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport mst_port (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

endinterface

// File: rtl/axi4_lite_reg_bank_wr_ch.sv
// Write channel of the register bank: captures AW and W independently,
// issues one commit per transaction, then holds B until accepted.
// Ports: i_aw_idx/i_awvalid/o_awready, i_wdata/i_wstrb/i_wvalid/o_wready,
//        o_bresp/o_bvalid/i_bready, o_cm_* commit strobe toward the registers.
module axi4_lite_reg_bank_wr_ch
    import axi4_lite_reg_bank_pkg::*;
#(
    parameter int IDX_W          = 2,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS       = 4
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic [IDX_W-1:0]            i_aw_idx,
    input  logic                        i_awvalid,
    output logic                        o_awready,
    input  logic [DATA_BIT_WIDTH-1:0]   i_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] i_wstrb,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    output logic [1:0]                  o_bresp,
    output logic                        o_bvalid,
    input  logic                        i_bready,
    output logic                        o_cm_en,
    output logic [IDX_W-1:0]            o_cm_idx,
    output logic [DATA_BIT_WIDTH-1:0]   o_cm_data,
    output logic [DATA_BIT_WIDTH/8-1:0] o_cm_strb
);

    localparam int STRB_W = DATA_BIT_WIDTH / 8;
    localparam logic [IDX_W:0] NREG = (IDX_W + 1)'(NUM_REGS);

    wr_state_t r_state, w_state_nxt;

    logic              r_aw_done, w_aw_done_nxt;
    logic              r_w_done,  w_w_done_nxt;
    logic              r_awready, w_awready_nxt;
    logic              r_wready,  w_wready_nxt;
    logic              r_bvalid,  w_bvalid_nxt;
    resp_t             r_bresp,   w_bresp_nxt;
    logic [IDX_W-1:0]  r_idx,     w_idx_nxt;
    logic [DATA_BIT_WIDTH-1:0] r_data, w_data_nxt;
    logic [STRB_W-1:0] r_strb,    w_strb_nxt;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_got;
    logic              w_w_got;
    logic              w_in_range;
    logic              w_cm_en;
    logic [IDX_W-1:0]  w_cur_idx;
    logic [DATA_BIT_WIDTH-1:0] w_cur_data;
    logic [STRB_W-1:0] w_cur_strb;

    assign w_aw_hs = i_awvalid & r_awready;
    assign w_w_hs  = i_wvalid & r_wready;

    assign w_aw_got = r_aw_done | w_aw_hs;
    assign w_w_got  = r_w_done | w_w_hs;

    // Payload taken straight from the bus when its handshake is this
    // cycle, so a same-edge AW+W commits without an extra capture cycle.
    assign w_cur_idx  = w_aw_hs ? i_aw_idx : r_idx;
    assign w_cur_data = w_w_hs  ? i_wdata  : r_data;
    assign w_cur_strb = w_w_hs  ? i_wstrb  : r_strb;

    assign w_in_range = {1'b0, w_cur_idx} < NREG;

    always_comb begin
        w_state_nxt   = r_state;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_idx_nxt     = r_idx;
        w_data_nxt    = r_data;
        w_strb_nxt    = r_strb;
        w_cm_en       = 1'b0;
        unique case (r_state)
            W_ACCEPT: begin
                w_idx_nxt  = w_cur_idx;
                w_data_nxt = w_cur_data;
                w_strb_nxt = w_cur_strb;
                if (w_aw_got && w_w_got) begin
                    w_state_nxt   = W_RESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_cm_en       = w_in_range;
                    if (w_in_range) begin
                        w_bresp_nxt = OKAY;
                    end else begin
                        w_bresp_nxt = SLVERR;
                    end
                end else begin
                    // Readies also come up here on the first edge after reset.
                    w_aw_done_nxt = w_aw_got;
                    w_w_done_nxt  = w_w_got;
                    w_awready_nxt = ~w_aw_got;
                    w_wready_nxt  = ~w_w_got;
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    w_state_nxt   = W_ACCEPT;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = W_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state   <= W_ACCEPT;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_idx     <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_idx     <= w_idx_nxt;
            r_data    <= w_data_nxt;
            r_strb    <= w_strb_nxt;
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;

    assign o_cm_en   = w_cm_en;
    assign o_cm_idx  = w_cur_idx;
    assign o_cm_data = w_cur_data;
    assign o_cm_strb = w_cur_strb;

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave register bank: holds NUM_REGS control registers,
// runs the read channel and delegates write handshaking to _wr_ch.
// Ports: i_clk, i_arst_n, s_axi (slave view), o_regs, o_wr_pulse.
// Optional assertions: define AXI4_LITE_REG_BANK_SVA_EN.
module axi4_lite_reg_bank
    import axi4_lite_reg_bank_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_REGS       = 4,
    parameter logic [DATA_BIT_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                                     i_clk,
    input  logic                                     i_arst_n,
    aix4_lite_if.slv_port                            s_axi,
    output logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0]  o_regs,
    output logic [NUM_REGS-1:0]                      o_wr_pulse
);

    localparam int OFS    = ofs_bits(DATA_BIT_WIDTH);
    localparam int IDX_W  = ADDR_BIT_WIDTH - OFS;
    localparam int STRB_W = DATA_BIT_WIDTH / 8;
    localparam logic [IDX_W:0] NREG = (IDX_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0]                     r_wr_pulse;

    logic                      w_cm_en;
    logic [IDX_W-1:0]          w_cm_idx;
    logic [DATA_BIT_WIDTH-1:0] w_cm_data;
    logic [STRB_W-1:0]         w_cm_strb;
    logic                      w_awready;
    logic                      w_wready;
    logic                      w_bvalid;
    logic [1:0]                w_bresp;

    axi4_lite_reg_bank_wr_ch #(
        .IDX_W          (IDX_W),
        .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
        .NUM_REGS       (NUM_REGS)
    ) u_wr_ch (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_aw_idx  (s_axi.awaddr[ADDR_BIT_WIDTH-1:OFS]),
        .i_awvalid (s_axi.awvalid),
        .o_awready (w_awready),
        .i_wdata   (s_axi.wdata),
        .i_wstrb   (s_axi.wstrb),
        .i_wvalid  (s_axi.wvalid),
        .o_wready  (w_wready),
        .o_bresp   (w_bresp),
        .o_bvalid  (w_bvalid),
        .i_bready  (s_axi.bready),
        .o_cm_en   (w_cm_en),
        .o_cm_idx  (w_cm_idx),
        .o_cm_data (w_cm_data),
        .o_cm_strb (w_cm_strb)
    );

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.bvalid  = w_bvalid;
    assign s_axi.bresp   = w_bresp;

    // An all-zero strobe is a legal no-op write: no update, no pulse.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_regs     <= {NUM_REGS{RST_VAL}};
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_cm_en && (w_cm_idx == IDX_W'(i)) && (|w_cm_strb)) begin
                    r_wr_pulse[i] <= 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_cm_strb[b]) begin
                            r_regs[i][b*8 +: 8] <= w_cm_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    assign o_regs     = r_regs;
    assign o_wr_pulse = r_wr_pulse;

    rd_state_t                 r_rd_state, w_rd_state_nxt;
    logic                      r_arready,  w_arready_nxt;
    logic                      r_rvalid,   w_rvalid_nxt;
    logic [DATA_BIT_WIDTH-1:0] r_rdata,    w_rdata_nxt;
    resp_t                     r_rresp,    w_rresp_nxt;

    logic [IDX_W-1:0]          w_ar_idx;
    logic                      w_ar_in_range;
    logic [DATA_BIT_WIDTH-1:0] w_rd_val;

    assign w_ar_idx      = s_axi.araddr[ADDR_BIT_WIDTH-1:OFS];
    assign w_ar_in_range = {1'b0, w_ar_idx} < NREG;

    // Reads sample r_regs before any same-edge commit lands,
    // so a colliding read returns the pre-write value.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) begin
                w_rd_val = r_regs[i];
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = r_arready;
        w_rvalid_nxt   = r_rvalid;
        w_rdata_nxt    = r_rdata;
        w_rresp_nxt    = r_rresp;
        unique case (r_rd_state)
            R_ACCEPT: begin
                if (s_axi.arvalid && r_arready) begin
                    w_rd_state_nxt = R_RESP;
                    w_arready_nxt  = 1'b0;
                    w_rvalid_nxt   = 1'b1;
                    w_rdata_nxt    = w_rd_val;
                    if (w_ar_in_range) begin
                        w_rresp_nxt = OKAY;
                    end else begin
                        w_rresp_nxt = SLVERR;
                    end
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    w_rd_state_nxt = R_ACCEPT;
                    w_rvalid_nxt   = 1'b0;
                    w_arready_nxt  = 1'b1;
                end
            end
            default: begin
                w_rd_state_nxt = R_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_rd_state <= R_ACCEPT;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rresp    <= w_rresp_nxt;
        end
    end

    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

    // Protection bits and sub-word address bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{s_axi.awprot, s_axi.arprot,
                        s_axi.awaddr[OFS-1:0], s_axi.araddr[OFS-1:0]};

`ifdef AXI4_LITE_REG_BANK_SVA_EN
    a_awvalid_hold: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.awvalid && !s_axi.awready |=> s_axi.awvalid);
    a_wvalid_hold: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.wvalid && !s_axi.wready |=> s_axi.wvalid);
    a_arvalid_hold: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.arvalid && !s_axi.arready |=> s_axi.arvalid);
    a_aw_stable: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.awvalid && !s_axi.awready |=>
        $stable({s_axi.awaddr, s_axi.awprot}));
    a_w_stable: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.wvalid && !s_axi.wready |=>
        $stable({s_axi.wdata, s_axi.wstrb}));
    a_ar_stable: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.arvalid && !s_axi.arready |=>
        $stable({s_axi.araddr, s_axi.arprot}));
    a_bvalid_hold: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.bvalid && !s_axi.bready |=> s_axi.bvalid);
    a_rvalid_hold: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        s_axi.rvalid && !s_axi.rready |=> s_axi.rvalid);
    a_valid_no_x: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        !$isunknown({s_axi.awvalid, s_axi.wvalid, s_axi.arvalid,
                     s_axi.bvalid, s_axi.rvalid}));
`else
`endif

endmodule
